// File: rtl/control_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// state codes, opcodes, ALU/mux selects and the control word.
package control_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       memto_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/unidad_control_multiciclo_if.sv
// Control bus between the control FSM (master) and the datapath (slave).
// Carries Op/MemReady in, all enables, selects and status out.
interface unidad_control_multiciclo_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         Op;
  logic               MemReady;
  logic               PCWrite;
  logic               PCWriteCond;
  logic [1:0]         PCSource;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic               InstrDone;
  logic               IllegalOp;
  logic [STATE_W-1:0] Estado;

  modport master (
    input  Op, MemReady,
    output PCWrite, PCWriteCond, PCSource, IorD,
    output MemRead, MemWrite, IRWrite, MemtoReg,
    output RegDst, RegWrite, ALUSrcA, ALUSrcB,
    output ALUOp, InstrDone, IllegalOp, Estado
  );

  modport slave (
    output Op, MemReady,
    input  PCWrite, PCWriteCond, PCSource, IorD,
    input  MemRead, MemWrite, IRWrite, MemtoReg,
    input  RegDst, RegWrite, ALUSrcA, ALUSrcB,
    input  ALUOp, InstrDone, IllegalOp, Estado
  );
endinterface

// File: rtl/unidad_control_multiciclo_decoder.sv
// Pure combinational state + MemReady -> control word decoder.
// Ports: state_i, mem_ready_i in; ctrl_o control word out.
module decodificador_salidas_control
  import control_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (1'b1)
      (state_i == FETCH): begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // IR and PC only advance once the fetch read completes
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      (state_i == DECODE): begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      (state_i == MEMADR),
      (state_i == ADDIEX): begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      (state_i == MEMRD): begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.ior_d    = 1'b1;
      end
      (state_i == MEMWB): begin
        ctrl_o.memto_reg  = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      (state_i == MEMWR): begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.ior_d      = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      (state_i == EXECUTE): begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      (state_i == ALUWB): begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      (state_i == BRANCH): begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REG;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
      end
      (state_i == ADDIWB): begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      (state_i == JUMP): begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Main control FSM of the multicycle MIPS datapath.
// Ports: clk, reset (sync, active-high), bus (master modport).
module unidad_control_multiciclo
  import control_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int STATE_W       = 4
) (
  input logic                          clk,
  input logic                          reset,
  unidad_control_multiciclo_if.master  bus
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   bad_op;
  logic   ready;
  ctrl_t  dec_w;
  ctrl_t  ctrl_w;

  assign ready = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

  always_comb begin
    state_d = FETCH;
    bad_op  = 1'b0;
    case (state_q)
      FETCH:  state_d = ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.Op)
          OP_LW,
          OP_SW:    state_d = MEMADR;
          OP_RTYPE: state_d = EXECUTE;
          OP_BEQ:   state_d = BRANCH;
          OP_ADDI:  state_d = ADDIEX;
          OP_J:     state_d = JUMP;
          default: begin
            state_d = FETCH;
            bad_op  = 1'b1;
          end
        endcase
      end
      MEMADR:  state_d = (bus.Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = ready ? MEMWB : MEMRD;
      MEMWR:   state_d = ready ? FETCH : MEMWR;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  assign illegal_d = illegal_q | bad_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  decodificador_salidas_control u_dec (
    .state_i     (state_q),
    .mem_ready_i (ready),
    .ctrl_o      (dec_w)
  );

  // Illegal opcode retires from DECODE; reset masks every strobe
  always_comb begin
    ctrl_w = dec_w;
    ctrl_w.instr_done = dec_w.instr_done | bad_op;
    if (reset) ctrl_w = '0;
  end

  assign bus.PCWrite     = ctrl_w.pc_write;
  assign bus.PCWriteCond = ctrl_w.pc_write_cond;
  assign bus.PCSource    = ctrl_w.pc_source;
  assign bus.IorD        = ctrl_w.ior_d;
  assign bus.MemRead     = ctrl_w.mem_read;
  assign bus.MemWrite    = ctrl_w.mem_write;
  assign bus.IRWrite     = ctrl_w.ir_write;
  assign bus.MemtoReg    = ctrl_w.memto_reg;
  assign bus.RegDst      = ctrl_w.reg_dst;
  assign bus.RegWrite    = ctrl_w.reg_write;
  assign bus.ALUSrcA     = ctrl_w.alu_src_a;
  assign bus.ALUSrcB     = ctrl_w.alu_src_b;
  assign bus.ALUOp       = ctrl_w.alu_op;
  assign bus.InstrDone   = ctrl_w.instr_done;
  assign bus.IllegalOp   = reset ? 1'b0 : illegal_q;
  assign bus.Estado      = reset ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Self-checking bench for unidad_control_multiciclo:
// per-cycle vector table with an expected-value queue.
module tb_unidad_control_multiciclo;

  logic clk;
  logic reset;

  unidad_control_multiciclo_if #(.STATE_W(4)) bus ();

  unidad_control_multiciclo #(
    .MEM_HANDSHAKE (1'b1),
    .STATE_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,PCSource,IorD,MemRead,MemWrite,IRWrite,
  //  MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,InstrDone}
  localparam logic [16:0] W_Z    = 17'b0_0_00_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [16:0] W_F1   = 17'b1_0_00_0_1_0_1_0_0_0_0_01_00_0;
  localparam logic [16:0] W_F0   = 17'b0_0_00_0_1_0_0_0_0_0_0_01_00_0;
  localparam logic [16:0] W_DEC  = 17'b0_0_00_0_0_0_0_0_0_0_0_11_00_0;
  localparam logic [16:0] W_DECI = 17'b0_0_00_0_0_0_0_0_0_0_0_11_00_1;
  localparam logic [16:0] W_MADR = 17'b0_0_00_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [16:0] W_MRD  = 17'b0_0_00_1_1_0_0_0_0_0_0_00_00_0;
  localparam logic [16:0] W_MWB  = 17'b0_0_00_0_0_0_0_1_0_1_0_00_00_1;
  localparam logic [16:0] W_MWR  = 17'b0_0_00_1_0_1_0_0_0_0_0_00_00_0;
  localparam logic [16:0] W_MWRD = 17'b0_0_00_1_0_1_0_0_0_0_0_00_00_1;
  localparam logic [16:0] W_EXE  = 17'b0_0_00_0_0_0_0_0_0_0_1_00_10_0;
  localparam logic [16:0] W_AWB  = 17'b0_0_00_0_0_0_0_0_1_1_0_00_00_1;
  localparam logic [16:0] W_BR   = 17'b0_1_01_0_0_0_0_0_0_0_1_00_01_1;
  localparam logic [16:0] W_AIWB = 17'b0_0_00_0_0_0_0_0_0_1_0_00_00_1;
  localparam logic [16:0] W_J    = 17'b1_0_10_0_0_0_0_0_0_0_0_00_00_1;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    bit          rst;
    logic [5:0]  op;
    bit          rdy;
    logic [3:0]  est;
    logic [16:0] w;
    bit          ill;
  } vec_t;

  typedef struct {
    logic [3:0]  est;
    logic [16:0] w;
    bit          ill;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_chk;
  int   n_fail;

  function automatic vec_t mk(bit r, logic [5:0] op, bit rdy,
                              logic [3:0] est, logic [16:0] w,
                              bit ill);
    vec_t v;
    v.rst = r;
    v.op  = op;
    v.rdy = rdy;
    v.est = est;
    v.w   = w;
    v.ill = ill;
    return v;
  endfunction

  function automatic logic [16:0] act_word();
    return {bus.PCWrite, bus.PCWriteCond, bus.PCSource, bus.IorD,
            bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg,
            bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
            bus.ALUOp, bus.InstrDone};
  endfunction

  task automatic chk(string name, int step, logic [31:0] got,
                     logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h want %h",
               name, step, got, want);
    end
  endtask

  initial begin
    exp_t e;
    reset        = 1'b1;
    bus.Op       = LW;
    bus.MemReady = 1'b1;
    n_chk        = 0;
    n_fail       = 0;

    // reset held 3 cycles
    repeat (3) vecs.push_back(mk(1, LW, 1, 0, W_Z, 0));
    // lw
    vecs.push_back(mk(0, LW, 1, 0, W_F1, 0));
    vecs.push_back(mk(0, LW, 1, 1, W_DEC, 0));
    vecs.push_back(mk(0, LW, 1, 2, W_MADR, 0));
    vecs.push_back(mk(0, LW, 1, 3, W_MRD, 0));
    vecs.push_back(mk(0, LW, 1, 4, W_MWB, 0));
    // sw with two wait states in MEMWR
    vecs.push_back(mk(0, SW, 1, 0, W_F1, 0));
    vecs.push_back(mk(0, SW, 1, 1, W_DEC, 0));
    vecs.push_back(mk(0, SW, 1, 2, W_MADR, 0));
    vecs.push_back(mk(0, SW, 0, 5, W_MWR, 0));
    vecs.push_back(mk(0, SW, 0, 5, W_MWR, 0));
    vecs.push_back(mk(0, SW, 1, 5, W_MWRD, 0));
    // fetch wait state, then beq
    vecs.push_back(mk(0, BEQ, 0, 0, W_F0, 0));
    vecs.push_back(mk(0, BEQ, 1, 0, W_F1, 0));
    vecs.push_back(mk(0, BEQ, 1, 1, W_DEC, 0));
    vecs.push_back(mk(0, BEQ, 1, 8, W_BR, 0));
    // j
    vecs.push_back(mk(0, JMP, 1, 0, W_F1, 0));
    vecs.push_back(mk(0, JMP, 1, 1, W_DEC, 0));
    vecs.push_back(mk(0, JMP, 1, 11, W_J, 0));
    // R-type
    vecs.push_back(mk(0, RT, 1, 0, W_F1, 0));
    vecs.push_back(mk(0, RT, 1, 1, W_DEC, 0));
    vecs.push_back(mk(0, RT, 1, 6, W_EXE, 0));
    vecs.push_back(mk(0, RT, 1, 7, W_AWB, 0));
    // addi
    vecs.push_back(mk(0, ADI, 1, 0, W_F1, 0));
    vecs.push_back(mk(0, ADI, 1, 1, W_DEC, 0));
    vecs.push_back(mk(0, ADI, 1, 9, W_MADR, 0));
    vecs.push_back(mk(0, ADI, 1, 10, W_AIWB, 0));
    // lw with a wait state in MEMRD
    vecs.push_back(mk(0, LW, 1, 0, W_F1, 0));
    vecs.push_back(mk(0, LW, 1, 1, W_DEC, 0));
    vecs.push_back(mk(0, LW, 1, 2, W_MADR, 0));
    vecs.push_back(mk(0, LW, 0, 3, W_MRD, 0));
    vecs.push_back(mk(0, LW, 1, 3, W_MRD, 0));
    vecs.push_back(mk(0, LW, 1, 4, W_MWB, 0));
    // illegal opcode, flag sticky across the next lw
    vecs.push_back(mk(0, BAD, 1, 0, W_F1, 0));
    vecs.push_back(mk(0, BAD, 1, 1, W_DECI, 0));
    vecs.push_back(mk(0, LW, 1, 0, W_F1, 1));
    vecs.push_back(mk(0, LW, 1, 1, W_DEC, 1));
    vecs.push_back(mk(0, LW, 1, 2, W_MADR, 1));
    vecs.push_back(mk(0, LW, 1, 3, W_MRD, 1));
    vecs.push_back(mk(0, LW, 1, 4, W_MWB, 1));
    // reset during a MEMRD wait state; clears the flag too
    vecs.push_back(mk(0, LW, 1, 0, W_F1, 1));
    vecs.push_back(mk(0, LW, 1, 1, W_DEC, 1));
    vecs.push_back(mk(0, LW, 1, 2, W_MADR, 1));
    vecs.push_back(mk(0, LW, 0, 3, W_MRD, 1));
    vecs.push_back(mk(1, LW, 0, 0, W_Z, 0));
    vecs.push_back(mk(0, LW, 1, 0, W_F1, 0));
    vecs.push_back(mk(0, LW, 1, 1, W_DEC, 0));
    vecs.push_back(mk(0, LW, 1, 2, W_MADR, 0));
    vecs.push_back(mk(0, LW, 1, 3, W_MRD, 0));
    vecs.push_back(mk(0, LW, 1, 4, W_MWB, 0));
    vecs.push_back(mk(0, SW, 1, 0, W_F1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset        = vecs[i].rst;
      bus.Op       = vecs[i].op;
      bus.MemReady = vecs[i].rdy;
      e.est = vecs[i].est;
      e.w   = vecs[i].w;
      e.ill = vecs[i].ill;
      sb.push_back(e);
      #1;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty step %0d", i);
      end else begin
        e = sb.pop_front();
        chk("Estado", i, 32'(bus.Estado), 32'(e.est));
        chk("ctrl_word", i, 32'(act_word()), 32'(e.w));
        chk("IllegalOp", i, 32'(bus.IllegalOp), 32'(e.ill));
      end
      chk("pcw_excl", i,
          32'(bus.PCWrite & bus.PCWriteCond), 32'd0);
      chk("mem_excl", i,
          32'(bus.MemRead & bus.MemWrite), 32'd0);
      chk("regw_excl", i,
          32'(bus.RegWrite & bus.MemWrite), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
